// File: rtl/vram_scanout_pkg.sv
// Shared scanout types and frame geometry, also used by the video timing block.
package vram_scanout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } ScanoutState;

  localparam int          FRAME_WIDTH              = 160;
  localparam int          FRAME_HEIGHT             = 120;
  localparam logic [31:0] DEFAULT_VRAM_BASE        = 32'h0000_C000;
  localparam int          DEFAULT_PIXELS_PER_FRAME = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int          DEFAULT_FIFO_DEPTH       = 4;

  // Four 8-bit pixels per 32-bit word; a partial last word still costs a full read.
  function automatic int words_for_pixels(input int pixels);
    return (pixels + 3) / 4;
  endfunction

endpackage

// File: rtl/scanout_word_fifo.sv
// Small synchronous word FIFO with flush; head word is always visible on head_data.
// Push and pop in the same cycle are allowed, including when full.
module scanout_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Each storage slot takes the pushed word only when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign mem_d[gi] = (push && !flush && (wr_ptr_q == PTR_W'(gi))) ? push_data : mem_q[gi];
  end

  // Pointer and occupancy update; flush empties the FIFO and wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/vram_scanout_reader.sv
// Scanout reader: fetches one frame of packed pixels from VRAM and streams them
// out over valid/ready, hiding the one-cycle RAM read latency.
// Optional macro VRAM_SCANOUT_DOUBLE_BUFFER_EN adds buffer_select/active_buffer.
module vram_scanout_reader
  import vram_scanout_pkg::*;
#(
  parameter logic [31:0] VRAM_BASE        = DEFAULT_VRAM_BASE,
  parameter int          PIXELS_PER_FRAME = DEFAULT_PIXELS_PER_FRAME,
  parameter int          FIFO_DEPTH       = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_start,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_data,
  output logic [7:0]  pixel_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_done,
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
  input  logic        buffer_select,
  output logic        active_buffer,
`endif
  output logic        underflow
);
  localparam int          WORDS      = words_for_pixels(PIXELS_PER_FRAME);
  localparam int          CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] WORDS_L    = 16'(WORDS);
  localparam logic [15:0] LAST_WORD  = 16'(WORDS - 1);
  localparam logic [15:0] LAST_PIXEL = 16'(PIXELS_PER_FRAME - 1);

  ScanoutState       state_q, state_d;
  logic [15:0]       wi_q, wi_d, pix_q, pix_d, word_sel;
  logic [1:0]        lane_q, lane_d;
  logic              inflight_q, inflight_d, underflow_q, underflow_d;
  logic              frame_done_q, frame_done_d;
  logic [31:0]       base_q, base_d, fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              issue, accept, final_accept, fifo_push, fifo_pop, room;
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
  localparam logic [31:0] FRAME_BYTES = 32'(4 * WORDS);
  logic active_buffer_q, active_buffer_d;
`endif

  scanout_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (mem_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: frame_start restarts from anywhere.
  always_comb begin
    state_d = state_q;
    if (frame_start) state_d = ACTIVE;
    else begin
      case (state_q)
        ACTIVE:  if (issue && (wi_q == LAST_WORD)) state_d = DRAIN;
        DRAIN:   if (final_accept) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: read issue, handshake and FIFO control. Counting the in-flight
  // read against the free space guarantees the returning word always fits.
  always_comb begin
    room         = (32'(fifo_count) + 32'(inflight_q)) < 32'(FIFO_DEPTH);
    issue        = (state_q == ACTIVE) && enable && room && (wi_q < WORDS_L);
    accept       = pixel_valid && pixel_ready;
    final_accept = accept && (pix_q == LAST_PIXEL);
    fifo_push    = inflight_q && !frame_start;
    fifo_pop     = accept && ((lane_q == 2'd3) || final_accept) && !frame_start;
  end

  // Datapath next values; frame_start clears everything and drops the in-flight read.
  always_comb begin
    wi_d         = wi_q;
    pix_d        = pix_q;
    lane_d       = lane_q;
    inflight_d   = issue;
    underflow_d  = underflow_q;
    frame_done_d = final_accept;
    base_d       = base_q;
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
    active_buffer_d = active_buffer_q;
`endif
    if (issue) wi_d = wi_q + 16'd1;
    if (accept) begin
      pix_d  = pix_q + 16'd1;
      lane_d = final_accept ? 2'd0 : lane_q + 2'd1;
    end
    if ((state_q == ACTIVE) && pixel_ready && !pixel_valid) underflow_d = 1'b1;
    if (frame_start) begin
      wi_d         = '0;
      pix_d        = '0;
      lane_d       = '0;
      inflight_d   = 1'b0;
      underflow_d  = 1'b0;
      frame_done_d = 1'b0;
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
      base_d          = VRAM_BASE + (buffer_select ? FRAME_BYTES : 32'd0);
      active_buffer_d = buffer_select;
`else
      base_d          = VRAM_BASE;
`endif
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wi_q         <= '0;
      pix_q        <= '0;
      lane_q       <= '0;
      inflight_q   <= 1'b0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
      base_q       <= VRAM_BASE;
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
      active_buffer_q <= 1'b0;
`endif
    end else begin
      wi_q         <= wi_d;
      pix_q        <= pix_d;
      lane_q       <= lane_d;
      inflight_q   <= inflight_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
      base_q       <= base_d;
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
      active_buffer_q <= active_buffer_d;
`endif
    end
  end

  // Address of the next word to read; once every word is issued it parks on the last one.
  always_comb begin
    word_sel    = (wi_q < WORDS_L) ? wi_q : LAST_WORD;
    mem_address = base_q + {14'd0, word_sel, 2'b00};
  end

  // Little-endian lane select from the FIFO head word; zero while nothing is buffered.
  always_comb begin
    pixel_data = 8'h00;
    if (pixel_valid) begin
      case (lane_q)
        2'd0:    pixel_data = fifo_head[7:0];
        2'd1:    pixel_data = fifo_head[15:8];
        2'd2:    pixel_data = fifo_head[23:16];
        default: pixel_data = fifo_head[31:24];
      endcase
    end
  end

  assign pixel_valid = (fifo_count != '0);
  assign frame_done  = frame_done_q;
  assign underflow   = underflow_q;
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
  assign active_buffer = active_buffer_q;
`endif

endmodule

// File: tb/tb_vram_scanout_reader.sv
// Scoreboard bench for vram_scanout_reader: stimulus pushes the expected pixel
// stream per frame, a negedge monitor pops and compares on every accept.
module tb_vram_scanout_reader;
  localparam logic [31:0] VRAM_BASE = 32'h0000C000;
  localparam int PPF       = 22;
  localparam int DEPTH     = 4;
  localparam int WORDS     = (PPF + 3) / 4;
  localparam int RAM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_ready = 1'b0;
  logic [31:0] mem_address;
  logic [31:0] mem_data = 32'd0;
  logic [7:0]  pixel_data;
  logic        pixel_valid, frame_done, underflow;
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
  logic        buffer_select = 1'b0;
  logic        active_buffer;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  sb [$];
  logic [31:0] cur_base = VRAM_BASE;
  int          acc_count = 0;
  logic        done_expect = 1'b0;
  logic        hold_prev = 1'b0;
  logic        expect_idle = 1'b0;
  logic [7:0]  data_prev = 8'd0;

  always #5 clk = ~clk;

  vram_scanout_reader #(
    .VRAM_BASE        (VRAM_BASE),
    .PIXELS_PER_FRAME (PPF),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .frame_start (frame_start),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .frame_done  (frame_done),
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
    .buffer_select (buffer_select),
    .active_buffer (active_buffer),
`endif
    .underflow   (underflow)
  );

  // Synchronous-read memory model: word appears the cycle after the address.
  always @(posedge clk) begin
    logic [31:0] off;
    off = mem_address - VRAM_BASE;
    if (off < 32'(4 * RAM_WORDS)) mem_data <= ram[off[7:2]];
    else                          mem_data <= 32'hDEADBEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: handshake checks, pixel order, frame_done timing, hold rule, address range.
  always @(negedge clk) begin
    logic        done_next;
    logic [7:0]  exp_px;
    logic [31:0] hi;
    done_next = 1'b0;
    if (rst) begin
      hold_prev   = 1'b0;
      expect_idle = 1'b1;
    end else begin
      if (expect_idle) begin
        check("valid_after_restart", 32'(pixel_valid), 32'd0);
        expect_idle = 1'b0;
      end
      if (frame_done || done_expect)
        check("frame_done", 32'(frame_done), 32'(done_expect));
      if (hold_prev) begin
        check("hold_valid", 32'(pixel_valid), 32'd1);
        check("hold_data", 32'(pixel_data), 32'(data_prev));
      end
      if (frame_start) begin
        expect_idle = 1'b1;
        hold_prev   = 1'b0;
      end else begin
        hi = cur_base + 32'(4 * (WORDS - 1));
        checks++;
        if (mem_address < cur_base || mem_address > hi || mem_address[1:0] != 2'b00) begin
          errors++;
          $display("FAIL mem_address_in_frame: got %h required %h..%h", mem_address, cur_base, hi);
        end
        if (pixel_valid) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL extra_pixel: got %h required no pixel at %0t", pixel_data, $time);
          end else if (pixel_ready) begin
            exp_px = sb.pop_front();
            check("pixel", 32'(pixel_data), 32'(exp_px));
            acc_count++;
            if (sb.size() == 0) done_next = 1'b1;
          end
        end
        hold_prev = pixel_valid && !pixel_ready;
        data_prev = pixel_data;
      end
    end
    done_expect = done_next;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // New frame: fresh memory contents, expected stream pushed to the scoreboard.
  task automatic start_frame();
    logic [31:0] b, w;
    logic [5:0]  wix, idx0;
    for (int i = 0; i < RAM_WORDS; i++) ram[6'(i)] = $urandom;
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
    buffer_select = 1'($urandom_range(0, 1));
    b = VRAM_BASE + (buffer_select ? 32'(4 * WORDS) : 32'd0);
`else
    b = VRAM_BASE;
`endif
    cur_base = b;
    idx0 = 6'((b - VRAM_BASE) >> 2);
    sb.delete();
    for (int k = 0; k < PPF; k++) begin
      wix = idx0 + 6'(k / 4);
      w = ram[wix];
      sb.push_back(w[8 * (k % 4) +: 8]);
    end
    acc_count = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("first_address", mem_address, cur_base);
    check("underflow_cleared", 32'(underflow), 32'd0);
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
    check("active_buffer", 32'(active_buffer), 32'(buffer_select));
`endif
  endtask

  task automatic wait_end(input bit rand_mode);
    int n = 0;
    while ((sb.size() != 0 || pixel_valid) && n < 3000) begin
      if (rand_mode) begin
        pixel_ready = ($urandom_range(0, 3) != 0);
        enable      = ($urandom_range(0, 7) != 0);
      end
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL frame_timeout: got %0d pixels left required 0", sb.size());
    end
    enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_accepts(input int target);
    int n = 0;
    while (acc_count < target && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (acc_count < target) begin
      errors++;
      $display("FAIL accept_timeout: got %0d accepts required %0d", acc_count, target);
    end
  endtask

  task automatic check_reset_values();
    check("rst_mem_address", mem_address, VRAM_BASE);
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_pixel_data", 32'(pixel_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
`ifdef VRAM_SCANOUT_DOUBLE_BUFFER_EN
    check("rst_active_buffer", 32'(active_buffer), 32'd0);
`endif
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values();
    rst = 1'b0;
    tick();

    // Streaming consumer: underflow sets while the pipe fills, second read follows.
    enable = 1'b1;
    pixel_ready = 1'b1;
    start_frame();
    tick();
    check("underflow_set", 32'(underflow), 32'd1);
    check("second_address", mem_address, cur_base + 32'd4);
    wait_end(0);

    // Stalled consumer: reads stop once FIFO plus in-flight reach the depth.
    pixel_ready = 1'b0;
    start_frame();
    repeat (20) tick();
    check("stall_address", mem_address, cur_base + 32'(4 * DEPTH));
    check("stall_valid", 32'(pixel_valid), 32'd1);
    check("stall_pixel", 32'(pixel_data), 32'(sb[0]));
    check("stall_no_underflow", 32'(underflow), 32'd0);
    pixel_ready = 1'b1;
    wait_end(0);

    // Abort after five pixels: stale data and frame_done must not appear.
    start_frame();
    wait_accepts(5);
    start_frame();
    wait_end(0);

    // Enable gap mid-frame: order preserved, underflow sticky until restart.
    start_frame();
    repeat (6) tick();
    enable = 1'b0;
    repeat (10) tick();
    enable = 1'b1;
    wait_end(0);
    check("underflow_sticky", 32'(underflow), 32'd1);

    // Restart coinciding with the final accept: no frame_done.
    start_frame();
    n = 0;
    while (!(sb.size() == 1 && pixel_valid) && n < 500) begin
      tick();
      n++;
    end
    check("last_pixel_reached", 32'(sb.size()), 32'd1);
    start_frame();
    wait_end(0);

    // Reset mid-frame returns to reset values.
    start_frame();
    repeat (8) tick();
    rst = 1'b1;
    sb.delete();
    cur_base = VRAM_BASE;
    tick();
    check_reset_values();
    rst = 1'b0;
    tick();
    start_frame();
    wait_end(0);

    // Randomized frames with random backpressure, enable gaps and aborts.
    for (int f = 0; f < 12; f++) begin
      start_frame();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 30)) begin
          pixel_ready = ($urandom_range(0, 3) != 0);
          enable      = ($urandom_range(0, 7) != 0);
          tick();
        end
        enable = 1'b1;
      end else begin
        wait_end(1);
      end
    end
    pixel_ready = 1'b1;
    start_frame();
    wait_end(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: got no finish required finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
